// File: rtl/cache_ctrl.sv
// cache_ctrl: sequencing controller for a 4-way set-associative, write-through,
// no-write-allocate cache with one word per line. It owns the valid/tag/data
// arrays and serves one CPU request at a time. The victim way on a read miss
// comes from an external LRU manager.
module cache_ctrl #(
  parameter int NUM_SETS   = 128,
  parameter int ASSOC      = 4,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  localparam int INDEX_BITS = $clog2(NUM_SETS),
  localparam int TAG_BITS   = ADDR_W - 2 - INDEX_BITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_W-1:0]     cpu_addr,
  input  logic [DATA_W-1:0]     cpu_wdata,
  output logic                  cpu_ready,
  output logic [DATA_W-1:0]     cpu_rdata,
  output logic                  cpu_hit,
  output logic                  busy,
  output logic                  lru_access,
  output logic [INDEX_BITS-1:0] lru_index,
  input  logic [1:0]            lru_way,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_W-1:0]     mem_rdata
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOOKUP = 3'd1;
  localparam logic [2:0] S_VICTIM = 3'd2;
  localparam logic [2:0] S_MEM_RD = 3'd3;
  localparam logic [2:0] S_MEM_WR = 3'd4;
  localparam logic [2:0] S_RESP   = 3'd5;

  logic [2:0]            state;
  logic [TAG_BITS-1:0]   req_tag;
  logic [INDEX_BITS-1:0] req_index;
  logic                  req_we;
  logic [DATA_W-1:0]     req_wdata;
  logic                  hit_q;
  logic [DATA_W-1:0]     rdata_q;

  logic [ASSOC-1:0]      valid_q [NUM_SETS];
  logic [TAG_BITS-1:0]   tag_q   [NUM_SETS][ASSOC];
  logic [DATA_W-1:0]     data_q  [NUM_SETS][ASSOC];

  logic                  lookup_hit;
  logic [1:0]            hit_way;
  logic                  refill_en;

  // Byte offset bits are ignored; the sink keeps lint quiet about them.
  logic unused_addr_bits;
  assign unused_addr_bits = &{1'b0, cpu_addr[1:0]};

  // Tag compare across the latched set; the lowest matching way wins, so the
  // loop runs high to low and the last assignment is the lowest way.
  // NOTE: every variable written here gets a default first, otherwise a
  // miss path would hold the old value and infer a latch.
  always_comb begin
    lookup_hit = 1'b0;
    hit_way    = 2'd0;
    for (int w = ASSOC - 1; w >= 0; w--) begin
      if (valid_q[req_index][w] && (tag_q[req_index][w] == req_tag)) begin
        lookup_hit = 1'b1;
        hit_way    = w[1:0];
      end
    end
  end

  assign refill_en = (state == S_MEM_RD) && mem_ack;

  // Control FSM plus the latched request and response registers.
  // NOTE: sequential state uses non-blocking assignments so every flop sees
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      req_tag   <= '0;
      req_index <= '0;
      req_we    <= 1'b0;
      req_wdata <= '0;
      hit_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cpu_req) begin
            req_tag   <= cpu_addr[ADDR_W-1:INDEX_BITS+2];
            req_index <= cpu_addr[INDEX_BITS+1:2];
            req_we    <= cpu_we;
            req_wdata <= cpu_wdata;
            state     <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          hit_q <= lookup_hit;
          if (req_we) begin
            state <= S_MEM_WR;
          end else if (lookup_hit) begin
            rdata_q <= data_q[req_index][hit_way];
            state   <= S_RESP;
          end else begin
            state <= S_VICTIM;
          end
        end
        S_VICTIM: state <= S_MEM_RD;
        S_MEM_RD: begin
          if (mem_ack) begin
            rdata_q <= mem_rdata;
            hit_q   <= 1'b0;
            state   <= S_RESP;
          end
        end
        S_MEM_WR: begin
          if (mem_ack) state <= S_RESP;
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Valid bits: cleared by reset, set when a refill lands in the victim way.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < NUM_SETS; s++) valid_q[s] <= '0;
    end else if (refill_en) begin
      valid_q[req_index][lru_way] <= 1'b1;
    end
  end

  // Tag and data storage: write-hit update and refill.
  // NOTE: these arrays carry no reset; valid gates every use, so clearing
  // them would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if ((state == S_LOOKUP) && req_we && lookup_hit) begin
      data_q[req_index][hit_way] <= req_wdata;
    end
    if (refill_en) begin
      tag_q[req_index][lru_way]  <= req_tag;
      data_q[req_index][lru_way] <= mem_rdata;
    end
  end

  assign busy       = (state != S_IDLE);
  assign cpu_ready  = (state == S_RESP);
  assign cpu_hit    = cpu_ready & hit_q;
  assign cpu_rdata  = rdata_q;
  assign lru_access = (state == S_VICTIM);
  assign lru_index  = req_index;
  assign mem_req    = (state == S_MEM_RD) || (state == S_MEM_WR);
  assign mem_we     = (state == S_MEM_WR);
  assign mem_addr   = {req_tag, req_index, 2'b00};
  assign mem_wdata  = req_wdata;

endmodule

// File: tb/tb_cache_ctrl.sv
// tb_cache_ctrl: directed bench for cache_ctrl with a behavioural memory and
// a per-set round-robin victim picker standing in for the LRU manager.
module tb_cache_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic        cpu_ready;
  logic [31:0] cpu_rdata;
  logic        cpu_hit;
  logic        busy;
  logic        lru_access;
  logic [6:0]  lru_index;
  logic [1:0]  lru_way;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;

  int errors = 0;
  int checks = 0;
  int unstable = 0;

  logic [31:0] mem_model [logic [31:0]];
  logic [1:0]  lru_ctr [128];

  cache_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_ready  (cpu_ready),
    .cpu_rdata  (cpu_rdata),
    .cpu_hit    (cpu_hit),
    .busy       (busy),
    .lru_access (lru_access),
    .lru_index  (lru_index),
    .lru_way    (lru_way),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  // Victim picker: hands out ways 0,1,2,3,0... per set, registered on the
  // lru_access edge.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      lru_way <= 2'd0;
      for (int s = 0; s < 128; s++) lru_ctr[s] <= 2'd0;
    end else if (lru_access) begin
      lru_way            <= lru_ctr[lru_index];
      lru_ctr[lru_index] <= lru_ctr[lru_index] + 2'd1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One CPU request; the memory acks k cycles after mem_req rises. Latency is
  // reported in the spec's counting (read hit = 2).
  task automatic run_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input int k, output logic [31:0] rdata, output logic hit,
                         output int lat, output int lru_n, output int mreq_n,
                         output logic [31:0] m_addr, output logic m_we,
                         output logic [31:0] m_wdata, output logic [6:0] l_idx);
    int  cnt;
    bit  done;
    rdata = '0; hit = 1'b0; lat = 0; lru_n = 0; mreq_n = 0;
    m_addr = '0; m_we = 1'b0; m_wdata = '0; l_idx = '0; cnt = 0; done = 1'b0;
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    @(posedge clk); #1;
    cpu_req = 1'b0;
    for (int c = 1; c <= 100 && !done; c++) begin
      @(posedge clk); #1;
      mem_ack = 1'b0;
      if (lru_access) begin
        lru_n++;
        l_idx = lru_index;
      end
      if (mem_req) begin
        if (cnt == 0) begin
          mreq_n++;
          m_addr = mem_addr; m_we = mem_we; m_wdata = mem_wdata;
        end else if (mem_addr !== m_addr || mem_we !== m_we || mem_wdata !== m_wdata) begin
          unstable++;
        end
        cnt++;
        if (cnt == k) begin
          mem_ack = 1'b1;
          if (mem_we) mem_model[mem_addr] = mem_wdata;
          else mem_rdata = mem_model.exists(mem_addr) ? mem_model[mem_addr] : ~mem_addr;
        end
      end else begin
        cnt = 0;
      end
      if (cpu_ready) begin
        rdata = cpu_rdata; hit = cpu_hit; lat = c + 1; done = 1'b1;
      end
    end
    mem_ack = 1'b0;
    check("ready_seen", 32'(done), 32'd1);
  endtask

  logic [31:0] rd, ma, mwd;
  logic        hit, mw;
  logic [6:0]  li;
  int          lat, lru_n, mr_n;

  initial begin
    mem_model[32'h100] = 32'hDEADBEEF;

    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(cpu_ready), 32'd0);
    check("rst_hit",   32'(cpu_hit), 32'd0);
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_lru",   32'(lru_access), 32'd0);
    check("rst_mreq",  32'(mem_req), 32'd0);
    check("rst_mwe",   32'(mem_we), 32'd0);
    check("rst_rdata", cpu_rdata, 32'h0);
    check("rst_maddr", mem_addr, 32'h0);
    check("rst_mwdat", mem_wdata, 32'h0);
    reset = 1'b0;

    // Cold read miss, memory answers 3 cycles after mem_req.
    run_req(1'b0, 32'h100, '0, 3, rd, hit, lat, lru_n, mr_n, ma, mw, mwd, li);
    check("miss_rdata", rd, 32'hDEADBEEF);
    check("miss_hit",   32'(hit), 32'd0);
    check("miss_lat",   32'(lat), 32'd6);
    check("miss_lru_n", 32'(lru_n), 32'd1);
    check("miss_lru_i", 32'(li), 32'h40);
    check("miss_mreqn", 32'(mr_n), 32'd1);
    check("miss_maddr", ma, 32'h100);
    check("miss_mwe",   32'(mw), 32'd0);

    // Same line, byte offset ignored: hit in 2 cycles.
    run_req(1'b0, 32'h103, '0, 1, rd, hit, lat, lru_n, mr_n, ma, mw, mwd, li);
    check("hit_rdata", rd, 32'hDEADBEEF);
    check("hit_hit",   32'(hit), 32'd1);
    check("hit_lat",   32'(lat), 32'd2);
    check("hit_lru_n", 32'(lru_n), 32'd0);
    check("hit_mreqn", 32'(mr_n), 32'd0);

    // Fill ways 1..3 of set 0x40, then 0x900 evicts way 0 (0x100).
    run_req(1'b0, 32'h300, '0, 1, rd, hit, lat, lru_n, mr_n, ma, mw, mwd, li);
    check("fill300_rd", rd, 32'hFFFFFCFF);
    check("fill300_lat", 32'(lat), 32'd4);
    run_req(1'b0, 32'h500, '0, 2, rd, hit, lat, lru_n, mr_n, ma, mw, mwd, li);
    check("fill500_hit", 32'(hit), 32'd0);
    run_req(1'b0, 32'h700, '0, 1, rd, hit, lat, lru_n, mr_n, ma, mw, mwd, li);
    check("fill700_lru", 32'(lru_n), 32'd1);
    run_req(1'b0, 32'h900, '0, 1, rd, hit, lat, lru_n, mr_n, ma, mw, mwd, li);
    check("fill900_hit", 32'(hit), 32'd0);
    run_req(1'b0, 32'h300, '0, 1, rd, hit, lat, lru_n, mr_n, ma, mw, mwd, li);
    check("keep300_hit", 32'(hit), 32'd1);
    check("keep300_rd",  rd, 32'hFFFFFCFF);

    // Write hit: write-through with the hit reported.
    run_req(1'b1, 32'h300, 32'h12345678, 2, rd, hit, lat, lru_n, mr_n, ma, mw, mwd, li);
    check("wrhit_hit",   32'(hit), 32'd1);
    check("wrhit_mwe",   32'(mw), 32'd1);
    check("wrhit_mwdat", mwd, 32'h12345678);
    check("wrhit_maddr", ma, 32'h300);
    check("wrhit_lat",   32'(lat), 32'd4);
    check("wrhit_lru_n", 32'(lru_n), 32'd0);
    run_req(1'b0, 32'h300, '0, 1, rd, hit, lat, lru_n, mr_n, ma, mw, mwd, li);
    check("rd300_hit", 32'(hit), 32'd1);
    check("rd300_rd",  rd, 32'h12345678);

    // 0x100 was evicted by 0x900: misses and refills.
    run_req(1'b0, 32'h100, '0, 1, rd, hit, lat, lru_n, mr_n, ma, mw, mwd, li);
    check("evict100_hit", 32'(hit), 32'd0);
    check("evict100_lru", 32'(lru_n), 32'd1);
    check("evict100_rd",  rd, 32'hDEADBEEF);

    // Write miss: no allocate, so the next read still misses.
    run_req(1'b1, 32'h2000, 32'hCAFEF00D, 1, rd, hit, lat, lru_n, mr_n, ma, mw, mwd, li);
    check("wrmiss_hit",   32'(hit), 32'd0);
    check("wrmiss_mwe",   32'(mw), 32'd1);
    check("wrmiss_lat",   32'(lat), 32'd3);
    check("wrmiss_lru_n", 32'(lru_n), 32'd0);
    run_req(1'b0, 32'h2000, '0, 1, rd, hit, lat, lru_n, mr_n, ma, mw, mwd, li);
    check("rd2000_hit", 32'(hit), 32'd0);
    check("rd2000_lru", 32'(lru_n), 32'd1);
    check("rd2000_rd",  rd, 32'hCAFEF00D);

    check("mem_stable", 32'(unstable), 32'd0);

    // Reset while waiting in MEM_RD: outputs drop at once.
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h4000;
    @(posedge clk); #1;
    cpu_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("abort_mreq_pre", 32'(mem_req), 32'd1);
    reset = 1'b1;
    #1;
    check("abort_mreq", 32'(mem_req), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_maddr", mem_addr, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    // All lines invalid after reset.
    run_req(1'b0, 32'h500, '0, 1, rd, hit, lat, lru_n, mr_n, ma, mw, mwd, li);
    check("postrst_hit", 32'(hit), 32'd0);
    check("postrst_lru", 32'(lru_n), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cache_ctrl.md
# cache_ctrl

Sequencing controller for the 4-way set-associative cache. It owns the tag, valid and data arrays and accepts one CPU word request at a time. On hit it serves from the arrays; on read miss it pulses the external LRU manager to get a victim way, then refills from memory. Writes are write-through with no write-allocate. It sits between the CPU port and the memory bus, with the LRU manager instantiated beside it.

## Interface
- NUM_SETS, 128, number of sets; power of two. INDEX_BITS = $clog2(NUM_SETS).
- ASSOC, 4, ways per set; fixed at 4 because lru_way is 2 bits.
- ADDR_W, 32, byte address width. TAG_BITS = ADDR_W - 2 - INDEX_BITS.
- DATA_W, 32, word and line width (one word per line).

- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  reset, asynchronous, active-high.
- cpu_req  in  1  request valid; sampled only in IDLE.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  byte address; [1:0] ignored, index = [INDEX_BITS+1:2], tag = [ADDR_W-1:INDEX_BITS+2].
- cpu_wdata  in  DATA_W  write data.
- cpu_ready  out  1  one-cycle completion pulse.
- cpu_rdata  out  DATA_W  read data; valid while cpu_ready = 1.
- cpu_hit  out  1  1 if the completed request hit; valid while cpu_ready = 1.
- busy  out  1  high whenever state != IDLE.
- lru_access  out  1  one-cycle pulse to the LRU manager.
- lru_index  out  INDEX_BITS  set index of the latched request.
- lru_way  in  2  victim way from the LRU manager; registered there on the lru_access edge.
- mem_req  out  1  memory request; held until mem_ack.
- mem_we  out  1  memory write.
- mem_addr  out  ADDR_W  word-aligned address {tag, index, 2'b00}.
- mem_wdata  out  DATA_W  memory write data.
- mem_ack  in  1  one-cycle completion from memory.
- mem_rdata  in  DATA_W  read data; valid with mem_ack.

## Operation
- Arrays: valid[NUM_SETS][4], tag[NUM_SETS][4], data[NUM_SETS][4]. Reset clears valid only; tag and data are not reset.
- FSM states: IDLE, LOOKUP, VICTIM, MEM_RD, MEM_WR, RESP.
- IDLE: if cpu_req is high, latch addr, we and wdata, then go to LOOKUP.
- LOOKUP:
  - A way hits when it is valid and its tag matches. If several ways match, the lowest-numbered way is used.
  - Read hit: load cpu_rdata from the data array, set hit = 1, go to RESP.
  - Read miss: go to VICTIM.
  - Write hit: update that way's data, then go to MEM_WR.
  - Write miss: leave the arrays unchanged, then go to MEM_WR.
- VICTIM: lru_access = 1 for exactly this cycle, then go to MEM_RD.
- MEM_RD:
  - Drive mem_req = 1 and mem_we = 0.
  - On mem_ack, write mem_rdata, the tag and valid = 1 into way lru_way of the set.
  - Set cpu_rdata = mem_rdata and hit = 0, then go to RESP.
- MEM_WR: drive mem_req = 1, mem_we = 1 and mem_wdata = latched wdata. On mem_ack go to RESP; hit reports the LOOKUP result.
- RESP: cpu_ready = 1, then go to IDLE.
- LRU handling:
  - lru_access fires only on a read miss.
  - Hits and writes never touch the LRU manager.
  - lru_index is driven from the latched index at all times.

## Timing
- Reset values: state IDLE, all valid bits 0. cpu_ready, cpu_hit, busy, lru_access, mem_req and mem_we are 0. cpu_rdata, mem_addr and mem_wdata are 0.
- Latency is counted from the accepting edge E0:
  - Read hit: cpu_ready in the cycle after E1, i.e. 2 cycles.
  - Read miss: mem_req rises after E2. If mem_ack arrives k cycles after mem_req rises (k ≥ 1), cpu_ready follows 3 + k cycles after E0.
  - Write: mem_req rises after E1; cpu_ready follows 2 + k cycles after E0.
- mem_req, mem_addr, mem_we and mem_wdata stay stable from assertion until mem_ack is sampled, and drop on the following edge.
- mem_ack outside MEM_RD or MEM_WR is ignored.
- cpu_req outside IDLE is ignored and not queued. The earliest next acceptance is the edge that ends RESP plus one, i.e. back-to-back hits run every 3 cycles.
- Reset mid-operation: all outputs go to reset values immediately (mem_req drops asynchronously). A pending refill is discarded and no array is written.

## Test plan
- Reset, then read 0x0000_0100 (index 0x40). Memory returns 0xDEADBEEF 3 cycles after mem_req -> one lru_access pulse with lru_index = 0x40, mem_addr = 0x100, mem_we = 0; cpu_ready with rdata 0xDEADBEEF, hit = 0.
- Read 0x0000_0103 right after -> cpu_ready 2 cycles after acceptance, rdata 0xDEADBEEF, hit = 1; no mem_req, no lru_access.
- With the real lru_manager, read 0x100, 0x300, 0x500, 0x700, 0x900 (same set) -> ways filled 0, 1, 2, 3, then 0. A following read of 0x100 misses and refills.
- Write 0x12345678 to 0x300 (hit) -> mem_req with mem_we = 1, mem_wdata 0x12345678, cpu_hit = 1. Next read of 0x300 hits and returns 0x12345678.
- Write to 0x2000 (miss) -> memory write, cpu_hit = 0. Next read of 0x2000 misses, with lru_access pulsed once.
- Assert reset while in MEM_RD before mem_ack -> mem_req and busy are 0 in the same cycle. After release, a read of any earlier address misses.
